// File: rtl/pu_msp430_pwm16.sv
// pu_msp430_pwm16: double-buffered single-channel 16-bit PWM with period-end event
module pu_msp430_pwm16 #(
    parameter int CLK_DIV = 1
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [15:0] cntrl_period,
    input  logic [15:0] cntrl_duty,
    output logic        pwm_out,
    output logic        period_evt,
    output logic [15:0] cnt_val,
    output logic        running
);
    localparam int PW = $clog2(CLK_DIV) + 1;
    localparam logic [PW-1:0] DIV_M1 = PW'(CLK_DIV - 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        r_state, w_state_nx;
    logic [PW-1:0] r_presc, w_presc_nx;
    logic [15:0]   r_cnt, w_cnt_nx, r_period_sh, w_period_nx, r_duty_sh, w_duty_nx;
    logic          r_pwm, r_evt, w_evt_nx, w_pwm_nx, w_tick, w_wrap;
    // next-state: prescaler, counter, shadow reload at wrap, and pwm from next-state values
    always_comb begin
        w_state_nx  = r_state;
        w_presc_nx  = r_presc;
        w_cnt_nx    = r_cnt;
        w_period_nx = r_period_sh;
        w_duty_nx   = r_duty_sh;
        w_evt_nx    = 1'b0;
        w_tick      = r_presc == DIV_M1;
        w_wrap      = r_state == RUN && w_tick && r_cnt == r_period_sh;
        if (r_state == IDLE) begin
            w_presc_nx = '0;
            w_cnt_nx   = '0;
            if (cntrl_period != 16'd0) begin
                w_period_nx = cntrl_period;
                w_duty_nx   = cntrl_duty;
                w_state_nx  = RUN;
            end
        end else begin
            w_presc_nx = w_tick ? '0 : r_presc + 1'b1;
            if (w_wrap) begin
                w_cnt_nx    = '0;
                w_evt_nx    = 1'b1;
                w_period_nx = cntrl_period;
                w_duty_nx   = cntrl_duty;
                if (cntrl_period == 16'd0) begin
                    w_state_nx = IDLE;
                    w_presc_nx = '0;
                end
            end else if (w_tick) begin
                w_cnt_nx = r_cnt + 16'd1;
            end
        end
        w_pwm_nx = w_state_nx == RUN && w_cnt_nx < w_duty_nx;
    end
    // state and datapath registers with synchronous reset
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            r_state     <= IDLE;
            r_presc     <= '0;
            r_cnt       <= '0;
            r_period_sh <= '0;
            r_duty_sh   <= '0;
            r_pwm       <= 1'b0;
            r_evt       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_presc     <= w_presc_nx;
            r_cnt       <= w_cnt_nx;
            r_period_sh <= w_period_nx;
            r_duty_sh   <= w_duty_nx;
            r_pwm       <= w_pwm_nx;
            r_evt       <= w_evt_nx;
        end
    end
    assign pwm_out    = r_pwm;
    assign period_evt = r_evt;
    assign cnt_val    = r_cnt;
    assign running    = r_state == RUN;
endmodule
